// File: rtl/clk_div_prog_pkg.sv
// Common types and default parameter values for the programmable
// clock divider. Values match the macros in clk_div_defs.vh.
package clk_div_prog_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DIV      = 11;

  // A channel either counts (enabled with a non-zero divisor) or sits idle
  // with its counter and output cleared.
  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_RUN  = 1'b1
  } chan_mode_e;

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider. The master
// side supplies enables, divisors and load strobes; the slave (the
// divider) returns the divided clocks, ticks and pending flags.
interface clk_div_prog_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);

  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*WIDTH-1:0] div_in;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pending;

  modport master (
    output en,
    output div_in,
    output load,
    input  clk_out,
    input  tick,
    input  pending
  );

  modport slave (
    input  en,
    input  div_in,
    input  load,
    output clk_out,
    output tick,
    output pending
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counts 0..act-1 and toggles clk_out on each wrap,
// giving a 2*act period square wave. A new divisor is parked in a shadow
// register and only swapped in on a wrap edge, so a half-period is never
// cut short; when idle or on a coinciding wrap it is applied directly.
module clk_div_chan
  import clk_div_prog_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] shd;
  chan_mode_e       mode;
  logic             wrap;

  // True when the counter sits on the last count of a half-period.
  function automatic logic at_last(input logic [WIDTH-1:0] c,
                                   input logic [WIDTH-1:0] a);
    return c == (a - WIDTH'(1));
  endfunction

  // Decode the channel mode and whether this edge ends a half-period.
  always_comb begin
    mode = MODE_IDLE;
    wrap = 1'b0;
    if (en && (act != '0)) begin
      mode = MODE_RUN;
      wrap = at_last(cnt, act);
    end
  end

  // Counter, output toggle and divisor shadowing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      act     <= WIDTH'(DEFAULT_DIV);
      shd     <= WIDTH'(DEFAULT_DIV);
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (mode == MODE_IDLE) begin
        // Nothing is mid-period, so a new divisor can take effect at once.
        cnt     <= '0;
        clk_out <= 1'b0;
        if (load) begin
          act     <= div_in;
          shd     <= div_in;
          pending <= 1'b0;
        end
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        if (load) begin
          act     <= div_in;
          shd     <= div_in;
          pending <= 1'b0;
        end else if (pending) begin
          act     <= shd;
          pending <= 1'b0;
        end
      end else begin
        cnt <= cnt + WIDTH'(1);
        if (load) begin
          shd     <= div_in;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_defs.vh
// Shared default configuration for the programmable clock divider.
// Kept as plain macros so the CPU top level can size its own wiring
// without importing the divider package.
`ifndef CLK_DIV_DEFS_VH
`define CLK_DIV_DEFS_VH

`define CLK_DIV_WIDTH        16
`define CLK_DIV_CHANNELS     2
`define CLK_DIV_DEFAULT_DIV  11

`endif

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: one independent clk_div_chan
// per channel, each fed its own slice of the divisor bus.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_prog_if.slave bus
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.en[k]),
      .load    (bus.load[k]),
      .div_in  (bus.div_in[k*WIDTH +: WIDTH]),
      .clk_out (bus.clk_out[k]),
      .tick    (bus.tick[k]),
      .pending (bus.pending[k])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with two 16-bit channels, default divisor 11.
module tb_clk_div_prog;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  clk_div_prog_if #(.WIDTH(16), .CHANNELS(2)) bus ();

  clk_div_prog #(
    .WIDTH       (16),
    .CHANNELS    (2),
    .DEFAULT_DIV (11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.en      = 2'b00;
    bus.load    = 2'b00;
    bus.div_in  = '0;
    edge_step();
    edge_step();
    reset = 1'b0;
  endtask

  task automatic idle_load(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] mask);
    bus.en     = 2'b00;
    bus.load   = mask;
    bus.div_in = {d1, d0};
    edge_step();
    bus.load   = 2'b00;
  endtask

  int exp31[13] = '{0,0,0,1,1,1,1,0,0,1,1,0,0};
  int exp32[14] = '{0,0,0,1,1,1,1,0,0,0,1,1,1,0};

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.en     = 2'b00;
    bus.load   = 2'b00;
    bus.div_in = '0;

    // Reset state before any clock edge.
    #1;
    chk("rst_clk_out", 32'(bus.clk_out), 0);
    chk("rst_tick",    32'(bus.tick),    0);
    chk("rst_pending", 32'(bus.pending), 0);

    // Default divisor 11: rise at edge 11, fall at 22, period 22.
    do_reset();
    bus.en = 2'b01;
    for (int e = 1; e <= 44; e++) begin
      edge_step();
      chk($sformatf("def_clk e%0d", e),  32'(bus.clk_out[0]), 32'((e / 11) % 2));
      chk($sformatf("def_tick e%0d", e), 32'(bus.tick[0]),    32'(e % 22 == 11));
    end

    // act=4, load 2 with cnt=1 in the high half: half-periods 4,4,2,2.
    do_reset();
    idle_load(16'd4, 16'd0, 2'b01);
    bus.en = 2'b01;
    for (int e = 1; e <= 13; e++) begin
      bus.load   = (e == 6) ? 2'b01 : 2'b00;
      bus.div_in = {16'd0, 16'd2};
      edge_step();
      chk($sformatf("shd_clk e%0d", e),  32'(bus.clk_out[0]), 32'(exp31[e-1]));
      chk($sformatf("shd_tick e%0d", e), 32'(bus.tick[0]),    32'(e == 4 || e == 10));
      if (e == 6 || e == 7) chk($sformatf("shd_pend e%0d", e), 32'(bus.pending[0]), 1);
      if (e >= 8)           chk($sformatf("shd_pend e%0d", e), 32'(bus.pending[0]), 0);
    end
    bus.load = 2'b00;

    // act=4, load 3 on the falling wrap edge: next half-period is 3.
    do_reset();
    idle_load(16'd4, 16'd0, 2'b01);
    bus.en = 2'b01;
    for (int e = 1; e <= 14; e++) begin
      bus.load   = (e == 8) ? 2'b01 : 2'b00;
      bus.div_in = {16'd0, 16'd3};
      edge_step();
      chk($sformatf("wrap_clk e%0d", e), 32'(bus.clk_out[0]), 32'(exp32[e-1]));
      if (e >= 8) chk($sformatf("wrap_pend e%0d", e), 32'(bus.pending[0]), 0);
    end
    bus.load = 2'b00;

    // act=0: silent for 50 cycles, then load 1 gives a toggle every cycle.
    do_reset();
    idle_load(16'd0, 16'd0, 2'b01);
    bus.en = 2'b01;
    for (int e = 1; e <= 50; e++) begin
      edge_step();
      chk($sformatf("zero_clk e%0d", e),  32'(bus.clk_out[0]), 0);
      chk($sformatf("zero_tick e%0d", e), 32'(bus.tick[0]),    0);
    end
    bus.load   = 2'b01;
    bus.div_in = {16'd0, 16'd1};
    edge_step();
    bus.load   = 2'b00;
    chk("zero_load_clk",  32'(bus.clk_out[0]), 0);
    chk("zero_load_pend", 32'(bus.pending[0]), 0);
    for (int e = 1; e <= 6; e++) begin
      edge_step();
      chk($sformatf("one_clk e%0d", e),  32'(bus.clk_out[0]), 32'(e % 2));
      chk($sformatf("one_tick e%0d", e), 32'(bus.tick[0]),    32'(e % 2));
    end

    // Async reset mid high half with a divisor pending.
    do_reset();
    bus.en = 2'b01;
    for (int e = 1; e <= 13; e++) begin
      bus.load   = (e == 13) ? 2'b01 : 2'b00;
      bus.div_in = {16'd0, 16'd7};
      edge_step();
    end
    bus.load = 2'b00;
    chk("ar_pre_pend", 32'(bus.pending[0]), 1);
    chk("ar_pre_clk",  32'(bus.clk_out[0]), 1);
    edge_step();
    edge_step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_clk",  32'(bus.clk_out[0]), 0);
    chk("ar_pend", 32'(bus.pending[0]), 0);
    chk("ar_tick", 32'(bus.tick[0]),    0);
    edge_step();
    reset = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      edge_step();
      chk($sformatf("ar_run_clk e%0d", e), 32'(bus.clk_out[0]), 32'((e / 11) % 2));
    end

    // Two channels at 3 and 5; channel 1 disabled from edge 21.
    do_reset();
    idle_load(16'd3, 16'd5, 2'b11);
    bus.en = 2'b11;
    for (int e = 1; e <= 40; e++) begin
      if (e == 21) bus.en = 2'b01;
      edge_step();
      chk($sformatf("ind_clk0 e%0d", e),  32'(bus.clk_out[0]), 32'((e / 3) % 2));
      chk($sformatf("ind_tick0 e%0d", e), 32'(bus.tick[0]),    32'(e % 6 == 3));
      chk($sformatf("ind_clk1 e%0d", e),  32'(bus.clk_out[1]), 32'((e < 21) ? (e / 5) % 2 : 0));
      chk($sformatf("ind_tick1 e%0d", e), 32'(bus.tick[1]),    32'(e < 21 && e % 10 == 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
